// File: rtl/imm_decode_stage.sv
// Immediate-generation stage for the RISC-V core.
// Decodes the immediate format (from the opcode or from imm_src), then extracts
// and extends the immediate to XLEN bits. The result is registered behind a
// valid/ready handshake. A one-entry skid register lets the stage keep full
// throughput without a combinational path from out_ready to in_ready.
// Results that carry an illegal type are counted as they leave the stage.
module imm_decode_stage #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [3:0]        imm_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm,
    output logic [3:0]        imm_type,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [3:0] T_I    = 4'd0;
    localparam logic [3:0] T_IU   = 4'd1;
    localparam logic [3:0] T_S    = 4'd2;
    localparam logic [3:0] T_B    = 4'd3;
    localparam logic [3:0] T_BU   = 4'd4;
    localparam logic [3:0] T_U    = 4'd5;
    localparam logic [3:0] T_J    = 4'd6;
    localparam logic [3:0] T_SH   = 4'd7;
    localparam logic [3:0] T_Z    = 4'd8;
    localparam logic [3:0] T_NONE = 4'd9;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [3:0]      dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [3:0]      imm_type_q, imm_type_d;
    logic            illegal_q, illegal_d;

    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [3:0]      skid_type_q, skid_type_d;
    logic            skid_illegal_q, skid_illegal_d;

    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    logic fire_in;
    logic fire_out;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Select the immediate type: derived from the opcode, or taken from imm_src.
    always_comb begin
        dec_type    = T_NONE;
        dec_illegal = 1'b0;
        if (AUTO_DECODE) begin
            case (opcode)
                7'b0010011: begin
                    if (funct3 == 3'b001 || funct3 == 3'b101) dec_type = T_SH;
                    else if (funct3 == 3'b011)                dec_type = T_IU;
                    else                                      dec_type = T_I;
                end
                7'b0000011,
                7'b1100111: dec_type = T_I;
                7'b0100011: dec_type = T_S;
                7'b1100011: begin
                    if (funct3 == 3'b110 || funct3 == 3'b111) dec_type = T_BU;
                    else                                      dec_type = T_B;
                end
                7'b0110111,
                7'b0010111: dec_type = T_U;
                7'b1101111: dec_type = T_J;
                7'b1110011: dec_type = funct3[2] ? T_Z : T_I;
                7'b0110011,
                7'b0001111: dec_type = T_NONE;
                default: begin
                    dec_type    = T_NONE;
                    dec_illegal = 1'b1;
                end
            endcase
        end else begin
            dec_type    = imm_src;
            dec_illegal = (imm_src >= 4'd10);
        end
    end

    // Extract and extend the immediate for the selected type; illegal types give zero.
    always_comb begin
        dec_imm = '0;
        if (!dec_illegal) begin
            case (dec_type)
                T_I:  dec_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
                T_IU: dec_imm = {{(XLEN-12){1'b0}}, instr[31:20]};
                T_S:  dec_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
                T_B:  dec_imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
                T_BU: dec_imm = {{(XLEN-13){1'b0}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
                T_U:  dec_imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
                T_J:  dec_imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                                 instr[20], instr[30:21], 1'b0};
                T_SH: begin
                    // RV64 shift amounts carry a sixth bit in instr[25].
                    if (XLEN == 64) dec_imm = {{(XLEN-6){1'b0}}, instr[25:20]};
                    else            dec_imm = {{(XLEN-5){1'b0}}, instr[24:20]};
                end
                T_Z:  dec_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
                default: dec_imm = '0;
            endcase
        end
    end

    // in_ready depends only on registered state and reset, so there is no
    // combinational path from out_ready back to the producer.
    assign in_ready = rst_n & ~skid_valid_q;
    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid_q & out_ready;

    // Next state for the output and skid registers plus the illegal counter.
    always_comb begin
        out_valid_d    = out_valid_q;
        imm_d          = imm_q;
        imm_type_d     = imm_type_q;
        illegal_d      = illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_type_d    = skid_type_q;
        skid_illegal_d = skid_illegal_q;
        illegal_cnt_d  = illegal_cnt_q;

        // A result leaving in the same cycle as a flush has still been consumed.
        if (fire_out && illegal_q && illegal_cnt_q != CNT_MAX) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // The skid register is only full while the output is also full,
            // and no input can fire, so the only move is a drain.
            if (out_ready) begin
                out_valid_d  = 1'b1;
                imm_d        = skid_imm_q;
                imm_type_d   = skid_type_q;
                illegal_d    = skid_illegal_q;
                skid_valid_d = 1'b0;
            end
        end else if (fire_in) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                imm_d       = dec_imm;
                imm_type_d  = dec_type;
                illegal_d   = dec_illegal;
            end else begin
                skid_valid_d   = 1'b1;
                skid_imm_d     = dec_imm;
                skid_type_d    = dec_type;
                skid_illegal_d = dec_illegal;
            end
        end else if (fire_out) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            imm_q          <= '0;
            imm_type_q     <= 4'd0;
            illegal_q      <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_type_q    <= 4'd0;
            skid_illegal_q <= 1'b0;
            illegal_cnt_q  <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            imm_q          <= imm_d;
            imm_type_q     <= imm_type_d;
            illegal_q      <= illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_type_q    <= skid_type_d;
            skid_illegal_q <= skid_illegal_d;
            illegal_cnt_q  <= illegal_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign imm         = imm_q;
    assign imm_type    = imm_type_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage.
// Instance a: XLEN=32, auto decode, small counter.
// Instance b: XLEN=64, auto decode.
// Instance c: XLEN=32, explicit imm_src.
module tb_imm_decode_stage;

    logic clk;
    logic rst_n;
    logic c_rst_n;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_illegal;
    logic [31:0] a_instr, a_imm;
    logic [3:0]  a_imm_src, a_imm_type, a_cnt;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_illegal;
    logic [31:0] b_instr;
    logic [63:0] b_imm;
    logic [3:0]  b_imm_src, b_imm_type;
    logic [15:0] b_cnt;

    logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_illegal;
    logic [31:0] c_instr, c_imm;
    logic [3:0]  c_imm_src, c_imm_type;
    logic [15:0] c_cnt;

    int n_total;
    int n_pass;

    imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .instr(a_instr), .imm_src(a_imm_src),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .imm(a_imm),
        .imm_type(a_imm_type), .illegal(a_illegal), .illegal_cnt(a_cnt)
    );

    imm_decode_stage #(.XLEN(64), .AUTO_DECODE(1'b1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .instr(b_instr), .imm_src(b_imm_src),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .imm(b_imm),
        .imm_type(b_imm_type), .illegal(b_illegal), .illegal_cnt(b_cnt)
    );

    imm_decode_stage #(.XLEN(32), .AUTO_DECODE(1'b0), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .flush(c_flush), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .instr(c_instr), .imm_src(c_imm_src),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .imm(c_imm),
        .imm_type(c_imm_type), .illegal(c_illegal), .illegal_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] addi_k(input int k);
        logic [31:0] w;
        w = k;
        return {w[11:0], 20'h00093};
    endfunction

    task automatic a_send(input string tag, input logic [31:0] ins,
                          input logic [31:0] e_imm, input logic [3:0] e_type,
                          input logic e_ill);
        a_instr    = ins;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
        chk({tag, "_valid"}, a_out_valid, 1'b1);
        chk({tag, "_imm"}, a_imm, e_imm);
        chk({tag, "_type"}, a_imm_type, e_type);
        chk({tag, "_ill"}, a_illegal, e_ill);
    endtask

    task automatic b_send(input string tag, input logic [31:0] ins,
                          input logic [63:0] e_imm, input logic [3:0] e_type);
        b_instr    = ins;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        chk({tag, "_valid"}, b_out_valid, 1'b1);
        chk({tag, "_imm"}, b_imm, e_imm);
        chk({tag, "_type"}, b_imm_type, e_type);
    endtask

    // Expected results for instr=0x80000000 indexed by imm_src.
    logic [31:0] c_exp_imm [16];

    initial begin
        int sent;
        int rcv;
        logic fi;
        logic fo;

        n_total = 0;
        n_pass  = 0;

        c_exp_imm[0]  = 32'hFFFFF800;
        c_exp_imm[1]  = 32'h00000800;
        c_exp_imm[2]  = 32'hFFFFF800;
        c_exp_imm[3]  = 32'hFFFFF000;
        c_exp_imm[4]  = 32'h00001000;
        c_exp_imm[5]  = 32'h80000000;
        c_exp_imm[6]  = 32'hFFF00000;
        for (int i = 7; i < 16; i++) c_exp_imm[i] = 32'h0;

        rst_n = 1'b0; c_rst_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_out_ready = 1; a_instr = 0; a_imm_src = 0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 1; b_instr = 0; b_imm_src = 0;
        c_flush = 0; c_in_valid = 0; c_out_ready = 1; c_instr = 0; c_imm_src = 0;

        step();
        step();
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_in_ready_low", a_in_ready, 1'b0);
        chk("rst_imm", a_imm, 32'h0);
        chk("rst_type", a_imm_type, 4'd0);
        chk("rst_illegal", a_illegal, 1'b0);
        chk("rst_cnt", a_cnt, 4'd0);
        rst_n = 1'b1; c_rst_n = 1'b1;
        step();
        chk("rel_in_ready", a_in_ready, 1'b1);
        chk("rel_out_valid", a_out_valid, 1'b0);

        // Auto decode, XLEN=32
        a_send("addi_m1", 32'hFFF00093, 32'hFFFFFFFF, 4'd0, 1'b0);
        a_send("beq_m4",  32'hFE000EE3, 32'hFFFFFFFC, 4'd3, 1'b0);
        a_send("bltu",    32'hFE006EE3, 32'h00001FFC, 4'd4, 1'b0);
        a_send("jal_2k",  32'h001000EF, 32'h00000800, 4'd6, 1'b0);
        a_send("slli3",   32'h00309093, 32'h00000003, 4'd7, 1'b0);
        a_send("sltiu",   32'hFFF0B093, 32'h00000FFF, 4'd1, 1'b0);
        a_send("sw_m4",   32'hFE112E23, 32'hFFFFFFFC, 4'd2, 1'b0);
        a_send("lui",     32'h12345037, 32'h12345000, 4'd5, 1'b0);
        a_send("csrwi",   32'h3400D073, 32'h00000001, 4'd8, 1'b0);
        a_send("add",     32'h002081B3, 32'h00000000, 4'd9, 1'b0);
        a_send("ill_7f",  32'hFFFFFFFF, 32'h00000000, 4'd9, 1'b1);
        chk("cnt_before_fire", a_cnt, 4'd0);
        step();
        chk("cnt_first", a_cnt, 4'd1);
        chk("drain_valid", a_out_valid, 1'b0);

        // Saturation: 19 more illegal results, cnt width 4
        a_instr = 32'h0000007F;
        for (int i = 0; i < 19; i++) begin
            a_in_valid = 1'b1;
            step();
            if (i == 13) chk("cnt_pre_sat", a_cnt, 4'd14);
        end
        a_in_valid = 1'b0;
        step();
        chk("cnt_sat", a_cnt, 4'hF);
        chk("sat_drain_valid", a_out_valid, 1'b0);

        // Backpressure: 8 addi with out_ready low for iterations 3..5
        sent = 0;
        rcv  = 0;
        for (int it = 0; it < 30 && rcv < 8; it++) begin
            a_in_valid  = (sent < 8);
            a_instr     = addi_k(sent + 1);
            a_out_ready = !(it >= 3 && it <= 5);
            fi = a_in_valid & a_in_ready;
            fo = a_out_valid & a_out_ready;
            if (fo) begin
                chk("bp_order", a_imm, rcv + 1);
                rcv++;
            end
            if (it == 4 || it == 5) begin
                chk("bp_hold_valid", a_out_valid, 1'b1);
                chk("bp_hold_imm", a_imm, 32'd3);
            end
            step();
            if (fi) sent++;
            if (it == 3) chk("bp_in_ready_drop", a_in_ready, 1'b0);
            if (it == 6) chk("bp_in_ready_back", a_in_ready, 1'b1);
        end
        a_in_valid = 1'b0;
        chk("bp_received", rcv, 8);
        chk("bp_sent", sent, 8);
        chk("bp_end_valid", a_out_valid, 1'b0);

        // Flush with the skid full and a simultaneous input
        a_out_ready = 1'b0;
        a_send("fl_x", addi_k(17), 32'd17, 4'd0, 1'b0);
        a_instr = addi_k(34); a_in_valid = 1'b1;
        step();
        chk("fl_skid_full", a_in_ready, 1'b0);
        a_instr = addi_k(51); a_in_valid = 1'b1; a_flush = 1'b1;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl_out_valid", a_out_valid, 1'b0);
        chk("fl_in_ready", a_in_ready, 1'b1);
        a_out_ready = 1'b1;
        step();
        chk("fl_gone1", a_out_valid, 1'b0);
        step();
        chk("fl_gone2", a_out_valid, 1'b0);
        chk("fl_cnt_kept", a_cnt, 4'hF);
        a_send("fl_after", addi_k(68), 32'd68, 4'd0, 1'b0);
        step();

        // XLEN=64
        b_send("lui64",   32'h800000B7, 64'hFFFFFFFF80000000, 4'd5);
        b_send("slli63",  32'h03F09093, 64'h000000000000003F, 4'd7);
        b_send("addi64",  32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 4'd0);
        b_send("jal64",   32'h001000EF, 64'h0000000000000800, 4'd6);
        step();

        // Explicit type sweep
        c_instr = 32'h80000000;
        for (int s = 0; s < 16; s++) begin
            c_imm_src  = s[3:0];
            c_in_valid = 1'b1;
            step();
            chk("sweep_valid", c_out_valid, 1'b1);
            chk("sweep_imm", c_imm, c_exp_imm[s]);
            chk("sweep_type", c_imm_type, s[3:0]);
            chk("sweep_ill", c_illegal, (s >= 10) ? 1'b1 : 1'b0);
        end
        c_in_valid = 1'b0;
        step();
        chk("sweep_cnt", c_cnt, 16'd6);

        // Reset mid-stream
        c_imm_src = 4'd5; c_out_ready = 1'b0; c_in_valid = 1'b1;
        step();
        step();
        chk("mid_skid_full", c_in_ready, 1'b0);
        c_rst_n = 1'b0;
        step();
        chk("mid_rst_valid", c_out_valid, 1'b0);
        chk("mid_rst_imm", c_imm, 32'h0);
        chk("mid_rst_cnt", c_cnt, 16'd0);
        c_rst_n = 1'b1; c_in_valid = 1'b0; c_out_ready = 1'b1;
        step();
        chk("mid_rel_ready", c_in_ready, 1'b1);
        chk("mid_rel_valid", c_out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
